// File: rtl/MovingAverage_types.sv
// Shared types for the moving-average UART transmitter.
// The PARITY state exists only when MOVINGAVERAGE_TX_PARITY_EN is defined.
package MovingAverage_types;

    localparam int DATA_BITS = 8;

    typedef logic signed [DATA_BITS-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef MOVINGAVERAGE_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/MovingAverage_baudgen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and ticks on the wrap (bit boundary).
module MovingAverage_baudgen #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic system1000,
    input  logic system1000_rstn,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Held clear while idle so the first bit after accept is a full period.
    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/movingaverage_uart_tx.sv
// UART transmitter for filtered signed samples: 8N1 frames, or 8E1 when
// MOVINGAVERAGE_TX_PARITY_EN is defined. tx and busy are registered.
module movingaverage_uart_tx
    import MovingAverage_types::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic    system1000,
    input  logic    system1000_rstn,
    input  sample_t s_data,
    input  logic    s_valid,
    output logic    s_ready,
    output logic    tx,
    output logic    busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t     state;
    sample_t    shift;
    logic [2:0] bit_cnt;
    logic       tick;
`ifdef MOVINGAVERAGE_TX_PARITY_EN
    logic       par;
`endif

    assign s_ready = (state == IDLE);

    MovingAverage_baudgen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baudgen (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .clear           (s_ready),
        .tick            (tick)
    );

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef MOVINGAVERAGE_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        shift <= s_data;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
`ifdef MOVINGAVERAGE_TX_PARITY_EN
                        par   <= ^s_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift <= {1'b0, shift[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
`ifdef MOVINGAVERAGE_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            // Present the next bit as this one's period ends.
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef MOVINGAVERAGE_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_movingaverage_uart_tx.sv
// Self-checking bench for movingaverage_uart_tx with CLKS_PER_BIT = 4.
module tb_movingaverage_uart_tx;

    localparam int C = 4;
`ifdef MOVINGAVERAGE_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * C;

    logic       system1000 = 1'b0;
    logic       system1000_rstn = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, tx, busy;

    int tests = 0;
    int fails = 0;

    movingaverage_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .tx              (tx),
        .busy            (busy)
    );

    always #5 system1000 = ~system1000;

    // Reference: bit i of the serial frame for sample d.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef MOVINGAVERAGE_TX_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Offer d, then check every cycle of the frame and the idle cycle after it.
    // hold keeps s_valid high with nxt as the next sample; stall jitters inputs.
    task automatic send(input logic [7:0] d, input bit hold, input logic [7:0] nxt,
                        input bit stall);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge system1000);
            n++;
        end
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout d=%h s_ready=%b want 1", d, s_ready);
            s_valid = 1'b0;
            return;
        end
        @(posedge system1000);
        @(negedge system1000);
        if (hold) s_data = nxt;
        else s_valid = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            tests++;
            if (tx !== exp_bit(d, k / C) || busy !== 1'b1 || s_ready !== 1'b0) begin
                fails++;
                $display("FAIL frame d=%h cyc=%0d tx=%b busy=%b rdy=%b want tx=%b busy=1 rdy=0",
                         d, k, tx, busy, s_ready, exp_bit(d, k / C));
            end
            if (stall) begin
                if (k < FRAME - C) begin
                    s_valid = 1'($urandom);
                    s_data  = 8'($urandom);
                end else begin
                    s_valid = 1'b0;
                end
            end
            @(negedge system1000);
        end
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL gap d=%h tx=%b busy=%b rdy=%b want 1 0 1", d, tx, busy, s_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge system1000);
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold tx=%b busy=%b want 1 0", tx, busy);
        end
        system1000_rstn = 1'b1;
        @(negedge system1000);
        tests++;
        if (s_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release rdy=%b tx=%b busy=%b want 1 1 0", s_ready, tx, busy);
        end
    endtask

    task automatic test_single();
        send(8'hA5, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), 1'b0, 8'h00, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge system1000);
        end
    endtask

    task automatic test_back_to_back();
        send(8'h7F, 1'b1, 8'h80, 1'b0);
        send(8'h80, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_stall();
        send(8'h3C, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 2 * C; k++) begin
            @(negedge system1000);
            tests++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL stall_extra cyc=%0d tx=%b busy=%b want 1 0", k, tx, busy);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        d = 8'($urandom) & 8'hF7;
        s_data  = d;
        s_valid = 1'b1;
        @(posedge system1000);
        @(negedge system1000);
        s_valid = 1'b0;
        repeat ((4 * C) + 1) @(negedge system1000);
        system1000_rstn = 1'b0;
        #1;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_async tx=%b busy=%b want 1 0", tx, busy);
        end
        @(negedge system1000);
        system1000_rstn = 1'b1;
        @(negedge system1000);
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_idle tx=%b busy=%b rdy=%b want 1 0 1", tx, busy, s_ready);
        end
        send(8'h01, 1'b0, 8'h00, 1'b0);
    endtask

`ifdef MOVINGAVERAGE_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        logic       want [2];
        vals[0] = 8'hA5; want[0] = 1'b0;
        vals[1] = 8'h01; want[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data  = vals[i];
            s_valid = 1'b1;
            @(posedge system1000);
            @(negedge system1000);
            s_valid = 1'b0;
            repeat (9 * C) @(negedge system1000);
            tests++;
            if (tx !== want[i]) begin
                fails++;
                $display("FAIL parity d=%h tx=%b want %b", vals[i], tx, want[i]);
            end
            repeat (2 * C) @(negedge system1000);
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL parity_len d=%h busy=%b want 0", vals[i], busy);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_stall();
        test_mid_reset();
`ifdef MOVINGAVERAGE_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
